// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared FSM encoding, ALU opcodes and helpers for the multiply/divide unit.
package multdiv_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;
  function automatic logic [63:0] min_int(input int w);
    return 64'd1 << (w - 1);
  endfunction
endpackage

// File: rtl/multdiv_unit_booth_enc.sv
// booth_radix4_enc: maps a radix-4 Booth triplet {b[i+1], b[i], b[i-1]} to {zero, neg, two}.
module booth_radix4_enc (
  input  logic [2:0] i_bits,
  output logic       o_zero,
  output logic       o_neg,
  output logic       o_two
);
  always_comb begin
    o_zero = (i_bits == 3'b000) || (i_bits == 3'b111);
    o_two  = (i_bits == 3'b011) || (i_bits == 3'b100);
    o_neg  = i_bits[2] && !o_zero;
  end
endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: multi-cycle signed radix-4 Booth multiplier / non-restoring divider sharing one datapath.
// Define MULTDIV_REMAINDER_EN to add the data_remainder output and its correction logic.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
`ifdef MULTDIV_REMAINDER_EN
  output logic [WIDTH-1:0] data_remainder,
`endif
  output logic             busy
);
  localparam logic [WIDTH-1:0] MIN_INT = WIDTH'(min_int(WIDTH));
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH+1:0]   r_acc;
  logic [WIDTH-1:0]   r_lo, r_m;
  logic               r_prev, r_neg_q, r_ovf, r_bz;
  logic               w_start, w_zero, w_neg, w_two, w_last, w_mexc;
  logic [WIDTH+1:0]   w_m_ext, w_pm, w_pp, w_msum, w_d, w_rsh, w_rnew;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quot;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_top;
`ifdef MULTDIV_REMAINDER_EN
  logic               r_neg_r;
  logic [WIDTH+1:0]   w_rfix;
  logic [WIDTH-1:0]   w_rem;
`endif

  booth_radix4_enc u_enc (
    .i_bits({r_lo[1:0], r_prev}),
    .o_zero(w_zero),
    .o_neg (w_neg),
    .o_two (w_two)
  );

  always_comb begin
    w_start = ctrl_MULT || ctrl_DIV;
    w_abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    w_abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    w_m_ext = {{2{r_m[WIDTH-1]}}, r_m};
    w_pm    = w_two ? (w_m_ext << 1) : w_m_ext;
    w_pp    = w_zero ? '0 : (w_neg ? -w_pm : w_pm);
    w_msum  = r_acc + w_pp;
    // divider works on magnitudes, so the divisor is zero-extended
    w_d     = {2'b00, r_m};
    w_rsh   = {r_acc[WIDTH:0], r_lo[WIDTH-1]};
    w_rnew  = w_rsh[WIDTH+1] ? w_rsh + w_d : w_rsh - w_d;
    w_prod  = {r_acc[WIDTH-1:0], r_lo};
    w_top   = w_prod[2*WIDTH-1:WIDTH-1];
    w_mexc  = !((&w_top) || !(|w_top));
    w_quot  = r_neg_q ? -r_lo : r_lo;
    w_last  = (r_state == MULT) ? (r_cnt == CNT_W'(WIDTH / 2))
            : (r_state == DIV) && (r_bz || r_cnt == CNT_W'(WIDTH));
`ifdef MULTDIV_REMAINDER_EN
    w_rfix  = r_acc[WIDTH+1] ? r_acc + w_d : r_acc;
    w_rem   = r_neg_r ? -w_rfix[WIDTH-1:0] : w_rfix[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_acc          <= '0;
      r_lo           <= '0;
      r_m            <= '0;
      r_prev         <= 1'b0;
      r_neg_q        <= 1'b0;
      r_ovf          <= 1'b0;
      r_bz           <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
      r_neg_r        <= 1'b0;
      data_remainder <= '0;
`endif
    end else begin
      data_resultRDY <= 1'b0;
      if (w_start) begin
        r_state        <= ctrl_MULT ? MULT : DIV;
        r_cnt          <= '0;
        r_acc          <= '0;
        r_lo           <= ctrl_MULT ? data_operandB : w_abs_a;
        r_m            <= ctrl_MULT ? data_operandA : w_abs_b;
        r_prev         <= 1'b0;
        r_neg_q        <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        r_ovf          <= (data_operandA == MIN_INT) && (&data_operandB);
        r_bz           <= ~|data_operandB;
        data_result    <= '0;
        data_exception <= 1'b0;
        busy           <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
        r_neg_r        <= data_operandA[WIDTH-1];
        data_remainder <= '0;
`endif
      end else if (r_state == MULT || r_state == DIV) begin
        if (w_last) begin
          r_state        <= DONE;
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
          data_result    <= (r_state == MULT) ? r_lo : (r_bz ? '0 : w_quot);
          data_exception <= (r_state == MULT) ? w_mexc : (r_bz || r_ovf);
`ifdef MULTDIV_REMAINDER_EN
          data_remainder <= (r_state == MULT || r_bz) ? '0 : w_rem;
`endif
        end else begin
          busy  <= 1'b1;
          r_cnt <= r_cnt + 1'b1;
          if (r_state == MULT) begin
            r_acc  <= {{2{w_msum[WIDTH+1]}}, w_msum[WIDTH+1:2]};
            r_lo   <= {w_msum[1:0], r_lo[WIDTH-1:2]};
            r_prev <= r_lo[1];
          end else begin
            r_acc <= w_rnew;
            r_lo  <= {r_lo[WIDTH-2:0], ~w_rnew[WIDTH+1]};
          end
        end
      end else if (r_state == DONE) begin
        r_state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: scoreboard bench for multdiv_unit with directed vectors (WIDTH=32).
module tb_multdiv_unit;
  localparam int W = 32;
  logic         clock = 1'b0, reset = 1'b0, ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
  logic [W-1:0] data_operandA = '0, data_operandB = '0;
  logic [W-1:0] data_result;
  logic         data_exception, data_resultRDY, busy;
  logic [W-1:0] rem;

  typedef struct {
    logic [W-1:0] res;
    logic         exc;
    logic [W-1:0] rem;
    int           lat;
    int           t0;
    string        name;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0, cyc = 0, n_rdy = 0, n_exp = 0, busy_cnt = 0;

  multdiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
`ifdef MULTDIV_REMAINDER_EN
    .data_remainder(rem),
`endif
    .busy(busy)
  );
`ifndef MULTDIV_REMAINDER_EN
  assign rem = '0;
`endif

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  always @(negedge clock) begin
    if (busy) busy_cnt++;
    if (data_resultRDY) begin
      n_rdy++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rdy: got RDY=1 at cycle %0d expected no RDY", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_res"}, 64'(data_result), 64'(e.res));
        chk({e.name, "_exc"}, 64'(data_exception), 64'(e.exc));
        chk({e.name, "_lat"}, 64'(cyc - e.t0), 64'(e.lat));
`ifdef MULTDIV_REMAINDER_EN
        chk({e.name, "_rem"}, 64'(rem), 64'(e.rem));
`endif
      end
    end
  end

  task automatic go(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b,
                    input bit push, input string nm, input logic [W-1:0] res, input bit exc,
                    input logic [W-1:0] r, input int lat);
    @(negedge clock);
    ctrl_MULT = m;
    ctrl_DIV = d;
    data_operandA = a;
    data_operandB = b;
    if (push) begin
      sb.push_back('{res, exc, r, lat, cyc + 1, nm});
      n_exp++;
    end
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    if (lat > 1) begin
      chk({nm, "_startclr_res"}, 64'(data_result), 64'd0);
      chk({nm, "_startclr_exc"}, 64'(data_exception), 64'd0);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #1;
    chk("rst_res", 64'(data_result), 64'd0);
    chk("rst_exc", 64'(data_exception), 64'd0);
    chk("rst_rdy", 64'(data_resultRDY), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    busy_cnt = 0;
    go(1, 0, 32'd7, -32'sd6, 1, "mul_7x-6", 32'hFFFFFFD6, 0, 0, 17);
    wait_idle();
    chk("busy_cycles", 64'(busy_cnt), 64'd16);
    chk("hold_res", 64'(data_result), 64'hFFFFFFD6);
    go(1, 0, 32'h00010000, 32'h00010000, 1, "mul_ovf", 32'h0, 1, 0, 17);
    wait_idle();
    go(1, 0, 32'h80000000, 32'd1, 1, "mul_min", 32'h80000000, 0, 0, 17);
    wait_idle();
    go(1, 0, -32'sd7, -32'sd8, 1, "mul_neg_neg", 32'd56, 0, 0, 17);
    wait_idle();
    go(1, 0, 32'h7FFFFFFF, 32'd2, 1, "mul_pos_ovf", 32'hFFFFFFFE, 1, 0, 17);
    wait_idle();
    go(1, 0, 32'h40000000, -32'sd2, 1, "mul_to_min", 32'h80000000, 0, 0, 17);
    wait_idle();
    go(0, 1, -32'sd17, 32'd5, 1, "div_-17/5", -32'sd3, 0, -32'sd2, 33);
    wait_idle();
    chk("hold_exc", 64'(data_exception), 64'd0);
    go(0, 1, 32'd123, 32'd0, 1, "div_by0", 32'd0, 1, 0, 1);
    wait_idle();
    chk("hold_by0_exc", 64'(data_exception), 64'd1);
    go(0, 1, 32'h80000000, 32'hFFFFFFFF, 1, "div_min/-1", 32'h80000000, 1, 0, 33);
    wait_idle();
    go(0, 1, 32'd100, -32'sd7, 1, "div_100/-7", -32'sd14, 0, 32'd2, 33);
    wait_idle();
    go(0, 1, -32'sd100, -32'sd7, 1, "div_-100/-7", 32'd14, 0, -32'sd2, 33);
    wait_idle();
    go(0, 1, 32'd7, 32'd100, 1, "div_7/100", 32'd0, 0, 32'd7, 33);
    wait_idle();
    go(0, 1, 32'h80000000, 32'd2, 1, "div_min/2", 32'hC0000000, 0, 0, 33);
    wait_idle();
    go(0, 1, 32'd100, 32'd7, 0, "div_abort", 32'd0, 0, 0, 33);
    repeat (8) @(negedge clock);
    go(1, 0, 32'd3, 32'd4, 1, "mul_restart", 32'd12, 0, 0, 17);
    wait_idle();
    go(1, 1, 32'd5, -32'sd3, 1, "mul_and_div", -32'sd15, 0, 0, 17);
    wait_idle();
    go(0, 1, 32'd100, 32'd7, 0, "div_reset", 32'd0, 0, 0, 33);
    repeat (7) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midrst_res", 64'(data_result), 64'd0);
    chk("midrst_exc", 64'(data_exception), 64'd0);
    chk("midrst_rdy", 64'(data_resultRDY), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    go(1, 0, 32'd2, 32'd3, 1, "mul_after_rst", 32'd6, 0, 0, 17);
    wait_idle();
    chk("rdy_count", 64'(n_rdy), 64'(n_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
